rram_inst_fifo: RTL and testbench
=================================

# rram_inst_fifo

Host-side instruction/data FIFO that feeds the RRAM crossbar controller. The host writes words through an active-low push port. The controller drains them through the `empty`/`pop_n`/`dout` handshake that it already uses for its instruction and input-data FIFOs. Reads are first-word-fall-through: the head word is presented on `dout` whenever `empty` is low. One instance serves the instruction stream (`WIDTH`=20); a second instance with `WIDTH`=64 serves input data.

## Interface
- `WIDTH`, 20, word width (INSTR_WIDTH+OPCODE_WIDTH; 64 for the data instance)
- `DEPTH`, 16, number of entries; power of two, ≥2
- `AF_LEVEL`, 12, `almost_full` threshold in entries, 1..DEPTH
- `CLK`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `push_n`  in  1  host write strobe, active-low
- `din`  in  WIDTH  host write data
- `full`  out  1  no free entry
- `almost_full`  out  1  count ≥ AF_LEVEL
- `pop_n`  in  1  controller read strobe, active-low
- `empty`  out  1  no valid entry
- `dout`  out  WIDTH  head word; forced to 0 while `empty`=1
- `flush`  in  1  synchronous discard of all contents, active-high
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `overflow`  out  1  sticky; a push was attempted while full
- `underflow`  out  1  sticky; a pop was attempted while empty

## Operation
- Storage is a DEPTH×WIDTH register array, addressed by a write pointer and a read pointer. Each pointer is $clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- `empty` = (wr_ptr == rd_ptr). `full` = (low bits equal and MSBs differ). `count` = wr_ptr − rd_ptr, truncated to the count width.
- Accepted push: `push_n`=0 and `full`=0 at the edge. `din` is written at `mem[wr_ptr]` and wr_ptr increments.
- Accepted pop: `pop_n`=0 and `empty`=0 at the edge. rd_ptr increments.
- `dout` is combinational from `mem[rd_ptr]`, gated to 0 when `empty`=1.
- Push while full: the push is dropped, contents are unchanged, and `overflow` is set. This holds even when a pop is accepted in the same cycle. `full` is the only admission criterion.
- Pop while empty: no pointer change, and `underflow` is set. This holds even when a push is accepted in the same cycle; the pushed word lands normally.
- Simultaneous accepted push and pop: both pointers advance and `count` is unchanged.
- `flush`=1: rd_ptr ← wr_ptr, so `count`=0 and `empty`=1 next cycle. `flush` has priority; push and pop in the same cycle are ignored and set no error flags. `flush` does not clear `overflow` or `underflow`.
- `overflow` and `underflow` clear only on reset.
- There is no state machine beyond the pointers; the occupancy states EMPTY, PARTIAL and FULL are derived from the pointers.

## Timing
- Reset (`reset`=0 at an edge): both pointers 0, `empty`=1, `full`=0, `almost_full`=0, `count`=0, `dout`=0, `overflow`=0, `underflow`=0. Reset overrides push, pop and flush. Reset mid-stream discards all entries.
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on `dout` with `empty`=0 after edge N. The controller may pop it at edge N+1.
- Pop-to-next-word latency is 0 extra cycles. After a pop at edge N, the next head word (or `empty`=1) is valid after edge N.
- All status outputs (`full`, `almost_full`, `empty`, `count`) are registered-pointer-derived and change only after clock edges. They reflect the post-edge state with no additional lag.
- Back-to-back pops every cycle are supported at full throughput. Back-to-back pushes every cycle are supported until `full`.
- The host must sample `full` before asserting `push_n`; a dropped push is reported only through `overflow`.

## Test plan
- **Reset state:** hold `reset`=0 for 2 cycles, then release. Require `empty`=1, `full`=0, `count`=0, `dout`=0 and both error flags 0.
- **Single word:** push 20'h4_0000. Require `empty`=0 and `dout`=20'h4_0000 after that edge. Pop; require `empty`=1 and `dout`=0.
- **Ordering and wrap:** push 20'h4_440A and 20'h4_C6FF, pop one, then push and pop 40 further words with interleaving. Require strict FIFO order across the pointer wrap and `count` tracking exactly at every edge.
- **Fill to full:** with `DEPTH`=16, push 16 words. Require `almost_full`=1 at `count`=12 and `full`=1 at `count`=16. Push a 17th word with `pop_n`=0 in the same cycle. Require the pop accepted, the push dropped, `count`=15, `overflow`=1 and data intact.
- **Underflow:** from `empty`, assert `pop_n`=0 together with a push of 20'h5_0000. Require `underflow`=1, `count`=1 and `dout`=20'h5_0000.
- **Flush and reset mid-operation:** with 5 entries, assert `flush` together with a push. Require `count`=0, `empty`=1, the push ignored and error flags retained. Refill 3 entries and drive `reset`=0 for one edge. Require the full reset state, including `overflow` and `underflow` cleared.

Source files
------------

// File: rtl/rram_inst_fifo_if.sv
// rram_inst_fifo_if
// Groups the host push port, the controller pop port and the status/error
// outputs of one rram_inst_fifo instance into a single bundle.
//   push_n, din        host write strobe (active-low) and write data
//   pop_n              controller read strobe (active-low)
//   flush              synchronous discard of all contents (active-high)
//   dout               head word, first-word-fall-through, 0 while empty
//   full, almost_full  admission status for the host
//   empty, count       occupancy status
//   overflow           sticky, a push hit a full FIFO
//   underflow          sticky, a pop hit an empty FIFO
// Modport master is the host/controller side; modport slave is the FIFO.
interface rram_inst_fifo_if #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 16
);
    logic                     push_n;
    logic [WIDTH-1:0]         din;
    logic                     full;
    logic                     almost_full;
    logic                     pop_n;
    logic                     empty;
    logic [WIDTH-1:0]         dout;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output push_n, din, pop_n, flush,
        input  full, almost_full, empty, dout, count, overflow, underflow
    );

    modport slave (
        input  push_n, din, pop_n, flush,
        output full, almost_full, empty, dout, count, overflow, underflow
    );
endinterface

// File: rtl/rram_inst_fifo.sv
// rram_inst_fifo
// Host-side instruction/data FIFO feeding the RRAM crossbar controller.
// First-word-fall-through: the head word is on dout whenever empty is low.
// Ports:
//   CLK    single clock, all state updates on the rising edge
//   reset  synchronous, active-low
//   bus    rram_inst_fifo_if.slave carrying push/pop/flush, data and status
// Parameters: WIDTH word width, DEPTH entries (power of two, >= 2),
// AF_LEVEL almost_full threshold in entries.
module rram_inst_fifo #(
    parameter int WIDTH    = 20,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                CLK,
    input  logic                reset,
    rram_inst_fifo_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             isEmpty;
    logic             isFull;
    logic [PW-1:0]    occupancy;
    logic             pushReq;
    logic             popReq;
    logic             pushAccept;
    logic             popAccept;

    // The extra pointer MSB separates "same slot, same lap" (empty) from
    // "same slot, one lap apart" (full).
    assign isEmpty   = (wrPtr_q == rdPtr_q);
    assign isFull    = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) &&
                       (wrPtr_q[AW] != rdPtr_q[AW]);
    assign occupancy = wrPtr_q - rdPtr_q;

    assign pushReq    = !bus.push_n;
    assign popReq     = !bus.pop_n;
    // Flush wins over both strobes; full/empty alone decide admission, so a
    // same-cycle pop never makes room for a push and vice versa.
    assign pushAccept = pushReq && !isFull  && !bus.flush;
    assign popAccept  = popReq  && !isEmpty && !bus.flush;

    assign bus.empty       = isEmpty;
    assign bus.full        = isFull;
    assign bus.count       = occupancy;
    assign bus.almost_full = (occupancy >= AF_THRESH);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.dout        = isEmpty ? '0 : mem_q[rdPtr_q[AW-1:0]];

    // Next-state for the pointers and sticky error flags. A flush drops the
    // contents by moving the read pointer onto the write pointer and leaves
    // the error flags untouched.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            rdPtr_d = wrPtr_q;
        end else begin
            if (pushAccept) begin
                wrPtr_d = wrPtr_q + PTR_ONE;
            end
            if (popAccept) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            if (pushReq && isFull) begin
                overflow_d = 1'b1;
            end
            if (popReq && isEmpty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Pointer and flag registers; reset overrides push, pop and flush.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array needs no reset: entries are only visible between the
    // pointers, and reset collapses that window to nothing.
    always_ff @(posedge CLK) begin
        if (reset && pushAccept) begin
            mem_q[wrPtr_q[AW-1:0]] <= bus.din;
        end
    end
endmodule

// File: tb/tb_rram_inst_fifo.sv
// tb_rram_inst_fifo
// Self-checking bench for rram_inst_fifo (WIDTH=20, DEPTH=16, AF_LEVEL=12).
// A queue holds the words the FIFO should contain; it is pushed when a push
// is accepted and its head is compared against dout when a pop is driven.
module tb_rram_inst_fifo;
    localparam int WIDTH    = 20;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic CLK = 1'b0;
    logic reset;

    rram_inst_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rram_inst_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [WIDTH-1:0] expQ [$];
    bit               expOverflow;
    bit               expUnderflow;
    int               assertCount = 0;
    int               failCount   = 0;

    // One clock edge with the given strobes; the reference queue and flags
    // are advanced at the edge, and outputs are sampled 1 ns later.
    task automatic drive(input logic pushN, input logic [WIDTH-1:0] data,
                         input logic popN, input logic fl);
        bit wasFull;
        bit wasEmpty;
        bus.push_n = pushN;
        bus.din    = data;
        bus.pop_n  = popN;
        bus.flush  = fl;
        @(posedge CLK);
        wasFull  = (expQ.size() == DEPTH);
        wasEmpty = (expQ.size() == 0);
        if (!reset) begin
            expQ.delete();
            expOverflow  = 1'b0;
            expUnderflow = 1'b0;
        end else if (fl) begin
            expQ.delete();
        end else begin
            if (!pushN && wasFull)  expOverflow  = 1'b1;
            if (!popN  && wasEmpty) expUnderflow = 1'b1;
            if (!popN  && !wasEmpty) void'(expQ.pop_front());
            if (!pushN && !wasFull) expQ.push_back(data);
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b1, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        idle();
        reset = 1'b1;
        idle();
        assertCount++; if (bus.empty !== 1'b1) begin failCount++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); end
        assertCount++; if (bus.full !== 1'b0) begin failCount++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
        assertCount++; if (bus.almost_full !== 1'b0) begin failCount++; $display("[TB] FAIL reset_almost_full: got %b expected 0", bus.almost_full); end
        assertCount++; if (bus.count !== CW'(0)) begin failCount++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        assertCount++; if (bus.dout !== 20'h0) begin failCount++; $display("[TB] FAIL reset_dout: got %h expected 0", bus.dout); end
        assertCount++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_flags: got ovf=%b unf=%b expected 0/0", bus.overflow, bus.underflow); end
    endtask

    task automatic test_single_word();
        drive(1'b0, 20'h4_0000, 1'b1, 1'b0);
        assertCount++; if (bus.empty !== 1'b0) begin failCount++; $display("[TB] FAIL single_empty: got %b expected 0", bus.empty); end
        assertCount++; if (bus.dout !== 20'h4_0000) begin failCount++; $display("[TB] FAIL single_dout: got %h expected 40000", bus.dout); end
        assertCount++; if (bus.count !== CW'(1)) begin failCount++; $display("[TB] FAIL single_count: got %0d expected 1", bus.count); end
        assertCount++; if (bus.dout !== expQ[0]) begin failCount++; $display("[TB] FAIL single_pop_data: got %h expected %h", bus.dout, expQ[0]); end
        drive(1'b1, '0, 1'b0, 1'b0);
        assertCount++; if (bus.empty !== 1'b1) begin failCount++; $display("[TB] FAIL single_empty_after_pop: got %b expected 1", bus.empty); end
        assertCount++; if (bus.dout !== 20'h0) begin failCount++; $display("[TB] FAIL single_dout_after_pop: got %h expected 0", bus.dout); end
    endtask

    task automatic test_ordering_wrap();
        logic [WIDTH-1:0] word;
        logic             popN;
        drive(1'b0, 20'h4_440A, 1'b1, 1'b0);
        drive(1'b0, 20'h4_C6FF, 1'b1, 1'b0);
        assertCount++; if (bus.dout !== 20'h4_440A) begin failCount++; $display("[TB] FAIL order_first_head: got %h expected 4440a", bus.dout); end
        drive(1'b1, '0, 1'b0, 1'b0);
        assertCount++; if (bus.dout !== 20'h4_C6FF) begin failCount++; $display("[TB] FAIL order_second_head: got %h expected 4c6ff", bus.dout); end
        for (int i = 0; i < 40; i++) begin
            word = WIDTH'($urandom);
            popN = (i % 3 == 0) ? 1'b1 : 1'b0;
            if (!popN) begin
                assertCount++; if (bus.dout !== expQ[0]) begin failCount++; $display("[TB] FAIL order_data[%0d]: got %h expected %h", i, bus.dout, expQ[0]); end
            end
            drive(1'b0, word, popN, 1'b0);
            assertCount++; if (bus.count !== CW'(expQ.size())) begin failCount++; $display("[TB] FAIL order_count[%0d]: got %0d expected %0d", i, bus.count, expQ.size()); end
        end
        for (int i = 0; i < DEPTH + 2 && expQ.size() != 0; i++) begin
            assertCount++; if (bus.dout !== expQ[0]) begin failCount++; $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, bus.dout, expQ[0]); end
            drive(1'b1, '0, 1'b0, 1'b0);
            assertCount++; if (bus.count !== CW'(expQ.size())) begin failCount++; $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", i, bus.count, expQ.size()); end
        end
        assertCount++; if (bus.empty !== 1'b1) begin failCount++; $display("[TB] FAIL order_final_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, WIDTH'(32'h2_0000 + i * 32'h111), 1'b1, 1'b0);
            assertCount++; if (bus.almost_full !== (expQ.size() >= AF_LEVEL)) begin failCount++; $display("[TB] FAIL fill_almost_full[%0d]: got %b expected %b", expQ.size(), bus.almost_full, expQ.size() >= AF_LEVEL); end
            assertCount++; if (bus.full !== (expQ.size() == DEPTH)) begin failCount++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", expQ.size(), bus.full, expQ.size() == DEPTH); end
        end
        assertCount++; if (bus.count !== CW'(16)) begin failCount++; $display("[TB] FAIL fill_count: got %0d expected 16", bus.count); end
        assertCount++; if (bus.dout !== expQ[0]) begin failCount++; $display("[TB] FAIL fill_pop_data: got %h expected %h", bus.dout, expQ[0]); end
        drive(1'b0, 20'hB_AD00, 1'b0, 1'b0);
        assertCount++; if (bus.count !== CW'(15)) begin failCount++; $display("[TB] FAIL full_push_pop_count: got %0d expected 15", bus.count); end
        assertCount++; if (bus.overflow !== 1'b1) begin failCount++; $display("[TB] FAIL full_overflow: got %b expected 1", bus.overflow); end
        assertCount++; if (bus.full !== 1'b0) begin failCount++; $display("[TB] FAIL full_after_drop: got %b expected 0", bus.full); end
        assertCount++; if (bus.underflow !== 1'b0) begin failCount++; $display("[TB] FAIL full_underflow: got %b expected 0", bus.underflow); end
        for (int i = 0; i < DEPTH && expQ.size() != 0; i++) begin
            assertCount++; if (bus.dout !== expQ[0]) begin failCount++; $display("[TB] FAIL full_drain_data[%0d]: got %h expected %h", i, bus.dout, expQ[0]); end
            drive(1'b1, '0, 1'b0, 1'b0);
        end
        assertCount++; if (bus.empty !== 1'b1) begin failCount++; $display("[TB] FAIL full_drain_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 20'h5_0000, 1'b0, 1'b0);
        assertCount++; if (bus.underflow !== 1'b1) begin failCount++; $display("[TB] FAIL underflow_flag: got %b expected 1", bus.underflow); end
        assertCount++; if (bus.count !== CW'(1)) begin failCount++; $display("[TB] FAIL underflow_count: got %0d expected 1", bus.count); end
        assertCount++; if (bus.dout !== 20'h5_0000) begin failCount++; $display("[TB] FAIL underflow_dout: got %h expected 50000", bus.dout); end
        assertCount++; if (bus.overflow !== 1'b1) begin failCount++; $display("[TB] FAIL underflow_overflow_kept: got %b expected 1", bus.overflow); end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 4; i++) drive(1'b0, WIDTH'(32'h6_0000 + i), 1'b1, 1'b0);
        assertCount++; if (bus.count !== CW'(5)) begin failCount++; $display("[TB] FAIL flush_pre_count: got %0d expected 5", bus.count); end
        drive(1'b0, 20'h1_2345, 1'b1, 1'b1);
        assertCount++; if (bus.count !== CW'(0)) begin failCount++; $display("[TB] FAIL flush_count: got %0d expected 0", bus.count); end
        assertCount++; if (bus.empty !== 1'b1 || bus.dout !== 20'h0) begin failCount++; $display("[TB] FAIL flush_empty: got empty=%b dout=%h expected 1/0", bus.empty, bus.dout); end
        assertCount++; if (bus.overflow !== expOverflow || bus.underflow !== expUnderflow) begin failCount++; $display("[TB] FAIL flush_flags: got ovf=%b unf=%b expected %b/%b", bus.overflow, bus.underflow, expOverflow, expUnderflow); end
        idle();
        assertCount++; if (bus.empty !== 1'b1) begin failCount++; $display("[TB] FAIL flush_push_ignored: got empty=%b expected 1", bus.empty); end
        for (int i = 0; i < 3; i++) drive(1'b0, WIDTH'(32'h7_0000 + i), 1'b1, 1'b0);
        assertCount++; if (bus.count !== CW'(3) || bus.dout !== 20'h7_0000) begin failCount++; $display("[TB] FAIL refill: got count=%0d dout=%h expected 3/70000", bus.count, bus.dout); end
        reset = 1'b0;
        drive(1'b0, 20'h8_8888, 1'b0, 1'b0);
        reset = 1'b1;
        assertCount++; if (bus.empty !== 1'b1 || bus.count !== CW'(0)) begin failCount++; $display("[TB] FAIL midreset_occupancy: got empty=%b count=%0d expected 1/0", bus.empty, bus.count); end
        assertCount++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.dout !== 20'h0) begin failCount++; $display("[TB] FAIL midreset_status: got full=%b af=%b dout=%h expected 0/0/0", bus.full, bus.almost_full, bus.dout); end
        assertCount++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_flags: got ovf=%b unf=%b expected 0/0", bus.overflow, bus.underflow); end
    endtask

    initial begin
        reset      = 1'b0;
        bus.push_n = 1'b1;
        bus.pop_n  = 1'b1;
        bus.flush  = 1'b0;
        bus.din    = '0;
        test_reset();
        test_single_word();
        test_ordering_wrap();
        test_fill_full();
        test_underflow();
        test_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
